// File: rtl/tx_bit_engine_if.sv
// Handshake and serial-line signals between the transmit controller and its host.
// The master side drives requests and frame settings; the slave side is the bit engine.
interface tx_bit_engine_if;
  logic       load;
  logic [7:0] data;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       btu;
  logic       doit;
  logic       tx;
  logic       txrdy;
  logic       done;

  modport master (
    output load, data, eight, pen, ohel, btu,
    input  doit, tx, txrdy, done
  );

  modport slave (
    input  load, data, eight, pen, ohel, btu,
    output doit, tx, txrdy, done
  );
endinterface

// File: rtl/tx_bit_engine.sv
// Serial transmit bit engine: frames a byte (start, 7/8 data, optional parity, stop)
// into a shift register and steps it out one bit per bit-time pulse.
//
// state | meaning
// IDLE  | line high, ready for load
// SEND  | frame in progress, one bit per btu
module tx_bit_engine (
  input logic             clk,
  input logic             reset,
  tx_bit_engine_if.slave  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [10:0] shreg;
  logic [3:0]  bitcnt;
  logic [3:0]  nbits;
  logic        doit_r;
  logic        txrdy_r;
  logic        done_r;

  logic        parity;
  logic [10:0] frame;
  logic [3:0]  frame_len;

  // Parity covers only the bits actually sent; ohel inverts to odd.
  always_comb begin
    parity    = (bus.eight ? ^bus.data : ^bus.data[6:0]) ^ bus.ohel;
    frame     = '1;
    frame_len = 4'd9;
    case ({bus.eight, bus.pen})
      2'b11: begin
        frame     = {1'b1, parity, bus.data, 1'b0};
        frame_len = 4'd11;
      end
      2'b10: begin
        frame     = {2'b11, bus.data, 1'b0};
        frame_len = 4'd10;
      end
      2'b01: begin
        frame     = {2'b11, parity, bus.data[6:0], 1'b0};
        frame_len = 4'd10;
      end
      default: begin
        frame     = {3'b111, bus.data[6:0], 1'b0};
        frame_len = 4'd9;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '1;
      bitcnt  <= '0;
      nbits   <= 4'd9;
      doit_r  <= 1'b0;
      txrdy_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            shreg   <= frame;
            nbits   <= frame_len;
            bitcnt  <= '0;
            state   <= SEND;
            doit_r  <= 1'b1;
            txrdy_r <= 1'b0;
          end
        end
        SEND: begin
          if (bus.btu) begin
            shreg  <= {1'b1, shreg[10:1]};
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == nbits - 4'd1) begin
              state   <= IDLE;
              shreg   <= '1;
              doit_r  <= 1'b0;
              txrdy_r <= 1'b1;
              done_r  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx    = shreg[0];
  assign bus.doit  = doit_r;
  assign bus.txrdy = txrdy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_tx_bit_engine.sv
// Directed bench for tx_bit_engine: hand-computed frames, noise loads, reset abort,
// and back-to-back frames with load held high.
module tb_tx_bit_engine;

  logic clk;
  logic reset;
  int   checks_total;
  int   checks_passed;

  tx_bit_engine_if bus ();

  tx_bit_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle three cycles then pulse btu: one bit time of four cycles.
  task automatic bit_time(input bit load_on_btu);
    for (int c = 0; c < 3; c++) tick();
    bus.btu = 1'b1;
    if (load_on_btu) bus.load = 1'b1;
    tick();
    bus.btu  = 1'b0;
    bus.load = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic e, input logic p, input logic o,
                            input logic [10:0] exp_bits, input int n, input bit noise);
    bus.data  = d;
    bus.eight = e;
    bus.pen   = p;
    bus.ohel  = o;
    bus.load  = 1'b1;
    tick();
    bus.load = 1'b0;
    if (noise) begin
      bus.data  = ~d;
      bus.eight = ~e;
      bus.pen   = ~p;
      bus.ohel  = ~o;
    end
    check("doit_start", bus.doit, 1'b1);
    check("txrdy_start", bus.txrdy, 1'b0);
    for (int i = 0; i < n; i++) begin
      check("tx_bit", bus.tx, exp_bits[i]);
      if (noise && i == 4) begin
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("txrdy_midload", bus.txrdy, 1'b0);
        check("tx_midload", bus.tx, exp_bits[i]);
        for (int c = 0; c < 2; c++) tick();
        bus.btu = 1'b1;
        tick();
        bus.btu = 1'b0;
      end else begin
        if (i < n - 1) check("done_mid", bus.done, 1'b0);
        bit_time(noise && i == n - 1);
      end
    end
    check("done_pulse", bus.done, 1'b1);
    check("txrdy_end", bus.txrdy, 1'b1);
    check("doit_end", bus.doit, 1'b0);
    check("tx_end", bus.tx, 1'b1);
    tick();
    check("done_clear", bus.done, 1'b0);
    check("no_queued_load", bus.doit, 1'b0);
    check("tx_idle", bus.tx, 1'b1);
  endtask

  initial begin
    logic [10:0] b2b;
    checks_total  = 0;
    checks_passed = 0;
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.data  = 8'h00;
    bus.eight = 1'b1;
    bus.pen   = 1'b0;
    bus.ohel  = 1'b0;
    bus.btu   = 1'b0;
    tick();
    tick();
    check("rst_tx", bus.tx, 1'b1);
    check("rst_doit", bus.doit, 1'b0);
    check("rst_txrdy", bus.txrdy, 1'b1);
    check("rst_done", bus.done, 1'b0);
    reset = 1'b0;
    tick();

    // btu while idle must not start anything
    for (int k = 0; k < 3; k++) begin
      bus.btu = 1'b1;
      tick();
    end
    bus.btu = 1'b0;
    check("idle_btu_txrdy", bus.txrdy, 1'b1);
    check("idle_btu_tx", bus.tx, 1'b1);
    check("idle_btu_doit", bus.doit, 1'b0);

    send_frame(8'h55, 1'b1, 1'b0, 1'b0, {2'b11, 8'h55, 1'b0}, 10, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0, {1'b1, 1'b0, 8'hA3, 1'b0}, 11, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, {1'b1, 1'b1, 8'hA3, 1'b0}, 11, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, {2'b11, 1'b0, 7'h7F, 1'b0}, 10, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, {2'b11, 8'h3C, 1'b0}, 10, 1'b1);

    // reset after the third bit time aborts the frame immediately
    bus.data  = 8'h55;
    bus.eight = 1'b1;
    bus.pen   = 1'b0;
    bus.load  = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int k = 0; k < 3; k++) bit_time(1'b0);
    check("pre_rst_doit", bus.doit, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", bus.tx, 1'b1);
    check("async_rst_doit", bus.doit, 1'b0);
    check("async_rst_txrdy", bus.txrdy, 1'b1);
    check("async_rst_done", bus.done, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, {2'b11, 8'h00, 1'b0}, 10, 1'b0);

    // load held high: one idle-high cycle between frames
    b2b       = {2'b11, 8'h0F, 1'b0};
    bus.data  = 8'h0F;
    bus.eight = 1'b1;
    bus.pen   = 1'b0;
    bus.load  = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 10; i++) begin
        check("b2b_tx", bus.tx, b2b[i]);
        check("b2b_done_low", bus.done, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        bus.btu = 1'b1;
        tick();
        bus.btu = 1'b0;
      end
      check("b2b_done", bus.done, 1'b1);
      check("b2b_gap_txrdy", bus.txrdy, 1'b1);
      check("b2b_gap_tx", bus.tx, 1'b1);
      tick();
      check("b2b_restart_txrdy", bus.txrdy, 1'b0);
      check("b2b_restart_done", bus.done, 1'b0);
    end
    bus.load = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/tx_bit_engine.md
TX_BIT_ENGINE -- requirements
Module: tx_bit_engine

Interface
REQ-001 The block SHALL run on one clock and an asynchronous, active-high reset, named as the codebase does: clk (rising edge) and reset.
REQ-002 Parameter: none; frame format is set at run time by the configuration inputs.
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 LOAD  input  1  request to transmit DATA; sampled only while TXRDY=1.
REQ-006 DATA  input  8  byte to send; bit 7 is ignored in 7-bit mode.
REQ-007 EIGHT  input  1  1 = 8 data bits, 0 = 7 data bits; sampled on accepted LOAD.
REQ-008 PEN  input  1  parity enable; sampled on accepted LOAD.
REQ-009 OHEL  input  1  1 = odd parity, 0 = even parity; sampled on accepted LOAD; ignored when PEN=0.
REQ-010 BTU  input  1  one-cycle bit-time-up pulse from the bit-time counter.
REQ-011 DOIT  output  1  enables the bit-time counter; high for the whole frame.
REQ-012 TX  output  1  serial line; idle high.
REQ-013 TXRDY  output  1  high when idle and able to accept LOAD.
REQ-014 DONE  output  1  one-cycle pulse when the last bit time of a frame ends.

Function
REQ-015 States SHALL be IDLE and SEND only.
REQ-016 IDLE: DOIT=0, TXRDY=1, TX=1, and the shift register holds all ones.
REQ-017 A LOAD is accepted only in IDLE; at that clock edge the block SHALL:
- compose an 11-bit shift register, LSB first: start 0, data bits, parity if PEN, then stop 1;
- fill every unused upper bit with 1;
- clear the bit counter;
- move to SEND, giving DOIT=1 and TXRDY=0 from the next cycle.
REQ-018 Frame length N: 7-bit/no parity = 9; 7-bit/parity = 10; 8-bit/no parity = 10; 8-bit/parity = 11.
REQ-019 Parity SHALL be the XOR of the 7 or 8 transmitted data bits when OHEL=0, and its inverse when OHEL=1.
REQ-020 TX SHALL equal shift-register bit 0 (registered source, no combinational path from inputs). The start bit therefore appears the cycle after LOAD is accepted.
REQ-021 On each BTU in SEND, the shift register SHALL shift right with a 1 shifted in, and the 4-bit bit counter SHALL increment.
REQ-022 On the BTU that takes the bit counter from N-1 to N, the block SHALL:
- go to IDLE;
- set DOIT=0 and TXRDY=1 on the next cycle;
- pulse DONE for that one next cycle.
REQ-023 BTU in IDLE SHALL be ignored.
REQ-024 LOAD in SEND SHALL be ignored and not queued, including a LOAD coincident with the final BTU.
REQ-025 Changes to DATA, EIGHT, PEN or OHEL during SEND SHALL NOT affect the frame in progress.
REQ-026 A LOAD held high continuously SHALL start a new frame on the first cycle TXRDY=1, giving back-to-back frames with one idle-high cycle between them.

Reset
REQ-027 While reset=1, asynchronously and regardless of state:
- state=IDLE, TX=1, DOIT=0, TXRDY=1, DONE=0;
- shift register = all ones, bit counter = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame. After release, the first LOAD SHALL start a complete new frame.

Verification
REQ-029 BTU every 4 cycles, LOAD with DATA=8'h55, EIGHT=1, PEN=0 -> TX sequence 0,1,0,1,0,1,0,1,0,1 (10 bits), DONE after the 10th BTU, TXRDY back to 1.
REQ-030 DATA=8'hA3, EIGHT=1, PEN=1, OHEL=0 -> parity bit 0, 11 bit times. Same data with OHEL=1 -> parity bit 1.
REQ-031 DATA=8'hFF, EIGHT=0, PEN=1, OHEL=1 -> 7 data bits of 1, parity 0, stop 1, N=10, and bit 7 is never sent.
REQ-032 LOAD with a different DATA asserted mid-frame and on the final-BTU cycle -> no effect on TX; TXRDY stays 0 until completion.
REQ-033 reset pulsed after the 3rd BTU of a frame -> TX=1, DOIT=0, TXRDY=1 in the same cycle. A subsequent LOAD of 8'h00 -> a full 10-bit frame.
REQ-034 LOAD held high with DATA=8'h0F -> consecutive frames separated by exactly one idle cycle, with DONE pulsing once per frame.
